// File: rtl/mdu_unit_if.sv
// Bus bundle between the E stage and the multiply/divide unit.
// Build option MDU_DIVZERO_FAST_EN is handled inside mdu_unit, not here.
interface mdu_unit_if;
    // start is a one-cycle pulse; it is accepted only when busy=0 and Req=0,
    // and busy then stays high for exactly the op latency (no ready back-pressure).
    logic        start;
    logic [3:0]  MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Req;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDU_out;
    logic [0:0]  state;

    modport master (
        output start, MDUOp, A, B, Req,
        input  busy, HI, LO, MDU_out, state
    );

    modport slave (
        input  start, MDUOp, A, B, Req,
        output busy, HI, LO, MDU_out, state
    );
endinterface

// File: rtl/mdu_unit.sv
// Multi-cycle MIPS multiply/divide unit holding HI/LO.
// Define MDU_DIVZERO_FAST_EN to make divide-by-zero complete with no busy cycles.
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic      clk,
    input  logic      reset,
    mdu_unit_if.slave bus
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [4:0] MULT_LAT = 5'(MULT_CYCLES);
    localparam logic [4:0] DIV_LAT  = 5'(DIV_CYCLES);

    logic [0:0]  state;
    logic [4:0]  cnt;
    logic [3:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic        md_op;
    logic        accept;
    logic        enter_run;
    logic [4:0]  lat;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    assign md_op  = (bus.MDUOp >= OP_MULT) && (bus.MDUOp <= OP_DIVU);
    assign accept = (state == S_IDLE) && bus.start && !bus.Req && md_op;

`ifdef MDU_DIVZERO_FAST_EN
    // A divide by zero leaves HI/LO alone anyway, so it is retired in the start cycle.
    assign enter_run = accept &&
                       !(((bus.MDUOp == OP_DIV) || (bus.MDUOp == OP_DIVU)) && (bus.B == 32'd0));
`else
    assign enter_run = accept;
`endif

    assign lat = ((op_q == OP_MULT) || (op_q == OP_MULTU)) ? MULT_LAT : DIV_LAT;

    always_comb begin
        res_hi = hi_q;
        res_lo = lo_q;
        case (op_q)
            OP_MULT: begin
                {res_hi, res_lo} = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
            end
            OP_MULTU: begin
                {res_hi, res_lo} = {32'd0, a_q} * {32'd0, b_q};
            end
            OP_DIV: begin
                // The overflowing case is pinned explicitly rather than left to the divider.
                if (b_q == 32'd0) begin
                    res_hi = hi_q;
                    res_lo = lo_q;
                end else if ((a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF)) begin
                    res_hi = 32'd0;
                    res_lo = 32'h8000_0000;
                end else begin
                    res_lo = $signed(a_q) / $signed(b_q);
                    res_hi = $signed(a_q) % $signed(b_q);
                end
            end
            OP_DIVU: begin
                if (b_q != 32'd0) begin
                    res_lo = a_q / b_q;
                    res_hi = a_q % b_q;
                end
            end
            default: begin
                res_hi = hi_q;
                res_lo = lo_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= 5'd0;
            op_q  <= 4'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            hi_q  <= 32'd0;
            lo_q  <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (enter_run) begin
                        state <= S_RUN;
                        cnt   <= 5'd1;
                        op_q  <= bus.MDUOp;
                        a_q   <= bus.A;
                        b_q   <= bus.B;
                    end else if (!bus.Req && (bus.MDUOp == OP_MTHI)) begin
                        hi_q <= bus.A;
                    end else if (!bus.Req && (bus.MDUOp == OP_MTLO)) begin
                        lo_q <= bus.A;
                    end
                end
                S_RUN: begin
                    if (cnt == lat) begin
                        state <= S_IDLE;
                        cnt   <= 5'd0;
                        hi_q  <= res_hi;
                        lo_q  <= res_lo;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        case (bus.MDUOp)
            OP_MFHI: bus.MDU_out = hi_q;
            OP_MFLO: bus.MDU_out = lo_q;
            default: bus.MDU_out = 32'd0;
        endcase
    end

    assign bus.busy  = (state == S_RUN);
    assign bus.HI    = hi_q;
    assign bus.LO    = lo_q;
    assign bus.state = state;
endmodule

// File: tb/tb_mdu_unit.sv
// Bench for mdu_unit: directed cases then random ops against a 64-bit arithmetic model.
module tb_mdu_unit;
    logic clk;
    logic reset;
    int   tests;
    int   fails;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic [63:0] exp_q[$];

    mdu_unit_if bus ();

    mdu_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // reference model: plain 64-bit arithmetic
    function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] hi,
                                               input logic [31:0] lo);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, uq, ur, up;
        logic [63:0]     res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        res = {hi, lo};
        case (op)
            4'd1: res = sa * sb;
            4'd2: begin up = ua * ub; res = up; end
            4'd3: if (b != 32'd0) begin
                q = sa / sb;
                r = sa % sb;
                res = {r[31:0], q[31:0]};
            end
            4'd4: if (b != 32'd0) begin
                uq = ua / ub;
                ur = ua % ub;
                res = {ur[31:0], uq[31:0]};
            end
            default: res = {hi, lo};
        endcase
        return res;
    endfunction

    function automatic int ref_latency(input logic [3:0] op, input logic [31:0] b, input bit req);
        if (req) return 0;
`ifdef MDU_DIVZERO_FAST_EN
        if ((op >= 4'd3) && (b == 32'd0)) return 0;
`endif
        return (op <= 4'd2) ? 5 : 10;
    endfunction

    // scoreboard compare
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, "_hi"}, bus.HI, exp_hi);
        chk({tag, "_lo"}, bus.LO, exp_lo);
        bus.MDUOp = 4'd5;
        #1 chk({tag, "_mfhi"}, bus.MDU_out, exp_hi);
        bus.MDUOp = 4'd6;
        #1 chk({tag, "_mflo"}, bus.MDU_out, exp_lo);
        bus.MDUOp = 4'd0;
        #1 chk({tag, "_out0"}, bus.MDU_out, 32'd0);
    endtask

    // driver: called at a negedge, returns at the negedge of the first non-busy cycle
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit req);
        int          n;
        int          cnt;
        logic [63:0] e;
        n = ref_latency(op, b, req);
        e = req ? {exp_hi, exp_lo} : ref_result(op, a, b, exp_hi, exp_lo);
        exp_q.push_back(e);
        bus.start = 1'b1;
        bus.MDUOp = op;
        bus.A     = a;
        bus.B     = b;
        bus.Req   = req;
        @(negedge clk);
        cnt = 0;
        while ((bus.busy === 1'b1) && (cnt < 40)) begin
            cnt++;
            // stray start / mthi / mtlo / Req while running must be ignored
            bus.start = 1'($urandom_range(0, 1));
            bus.MDUOp = 4'($urandom_range(1, 8));
            bus.A     = $urandom;
            bus.B     = $urandom;
            bus.Req   = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.MDUOp = 4'd0;
        bus.Req   = 1'b0;
        chk({tag, "_busy_cycles"}, 32'(cnt), 32'(n));
        e = exp_q.pop_front();
        exp_hi = e[63:32];
        exp_lo = e[31:0];
        chk_regs(tag);
    endtask

    task automatic mt(input string tag, input logic [3:0] op, input logic [31:0] v, input bit req);
        bus.MDUOp = op;
        bus.A     = v;
        bus.Req   = req;
        @(negedge clk);
        bus.MDUOp = 4'd0;
        bus.Req   = 1'b0;
        if (!req && op == 4'd7) exp_hi = v;
        if (!req && op == 4'd8) exp_lo = v;
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk_regs(tag);
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b;
        bit          req;
        tests = 0;
        fails = 0;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        bus.start = 1'b0;
        bus.MDUOp = 4'd0;
        bus.A = 32'd0;
        bus.B = 32'd0;
        bus.Req = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk_regs("reset");

        run_op("mult_neg1x2", 4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
        chk("mult_hi_const", bus.HI, 32'hFFFF_FFFF);
        chk("mult_lo_const", bus.LO, 32'hFFFF_FFFE);
        run_op("multu_ffx2", 4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
        chk("multu_hi_const", bus.HI, 32'h0000_0001);
        run_op("div_m7_2", 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("div_lo_const", bus.LO, 32'hFFFF_FFFD);
        chk("div_hi_const", bus.HI, 32'hFFFF_FFFF);
        run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("div_ovf_lo_const", bus.LO, 32'h8000_0000);
        chk("div_ovf_hi_const", bus.HI, 32'd0);

        mt("mthi", 4'd7, 32'h1234_5678, 1'b0);
        mt("mtlo", 4'd8, 32'hCAFE_0001, 1'b0);
        mt("mthi_req", 4'd7, 32'hDEAD_BEEF, 1'b1);
        run_op("divu_zero", 4'd4, 32'd99, 32'd0, 1'b0);
        chk("divu_zero_hi_const", bus.HI, 32'h1234_5678);
        run_op("div_zero", 4'd3, 32'd99, 32'd0, 1'b0);
        run_op("mult_req", 4'd1, 32'd3, 32'd4, 1'b1);
        run_op("mult_3x4", 4'd1, 32'd3, 32'd4, 1'b0);
        run_op("b2b_divu", 4'd4, 32'd1000, 32'd7, 1'b0);

        // reset during cycle 3 of a divide
        bus.start = 1'b1;
        bus.MDUOp = 4'd3;
        bus.A = 32'd100;
        bus.B = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        bus.MDUOp = 4'd0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        chk("midreset_busy", 32'(bus.busy), 32'd0);
        chk_regs("midreset");
        repeat (12) @(negedge clk);
        chk("midreset_late_busy", 32'(bus.busy), 32'd0);
        chk_regs("midreset_late");

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 9) < 2) begin
                mt("rnd_mt", 4'($urandom_range(7, 8)), $urandom, ($urandom_range(0, 3) == 0));
            end else begin
                op  = 4'($urandom_range(1, 4));
                a   = $urandom;
                b   = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
                if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
                req = ($urandom_range(0, 7) == 0);
                run_op("rnd_op", op, a, b, req);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multiply/divide unit in the E stage of the 5-stage MIPS pipeline.
- Executes mult, multu, div and divu over a fixed multi-cycle latency, and holds the HI/LO registers.
- Serves mfhi/mflo reads and mthi/mtlo writes.
- Drives `busy` to the hazard/stall unit. That unit freezes D while any MD instruction in D meets `busy|start`.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..31).
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..31).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  E-stage instruction is mult/multu/div/divu; high for exactly one cycle per op
- MDUOp  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; others = none
- A  input  32  forwarded rs value
- B  input  32  forwarded rt value
- Req  input  1  exception/interrupt taken this cycle; E instruction is flushed
- busy  output  1  operation in progress
- HI  output  32  HI register
- LO  output  32  LO register
- MDU_out  output  32  HI when MDUOp=5, LO when MDUOp=6, else 0 (combinational)

Behaviour:
- Reset: one clock-edge synchronous reset, active-high, `clk` only. On that edge: busy=0, HI=0, LO=0, cycle counter=0, latched operands/op cleared.
- Reset mid-operation: the in-flight result is discarded and HI/LO become 0.
- States:
  - IDLE → RUN when start=1, MDUOp in 1..4, Req=0.
  - RUN → IDLE when counter reaches the latency.
  - RUN ignores start and MDUOp 7/8. The stall unit guarantees none arrive; the bench checks they have no effect.
- Start:
  - Start cycle T: A, B and op are latched at the T edge.
  - busy=1 during cycles T+1 .. T+N, where N = MULT_CYCLES or DIV_CYCLES.
  - The result is written to HI/LO at the edge ending T+N. It is visible in cycle T+N+1, when busy=0 again.
  - Back-to-back: a new start is legal in cycle T+N+1.
- Req=1 in the start cycle: start is suppressed, busy stays 0, HI/LO unchanged.
- Req=1 while RUN: no effect. The operation was committed in an earlier cycle and runs to completion.
- mult: {HI,LO} = signed(A) × signed(B), full 64 bits.
- multu: {HI,LO} = unsigned product, full 64 bits.
- div:
  - LO = quotient truncated toward zero.
  - HI = remainder, sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: LO = A/B, HI = A%B, unsigned.
- Divide by zero (B=0 at start, div or divu): HI/LO keep their prior values. Busy timing is defined under Optional Feature.
- mthi/mtlo (MDUOp 7/8):
  - In IDLE with Req=0: HI (resp. LO) := A at that edge.
  - Req=1: no write.
- Same-edge collision: an mthi/mtlo edge coinciding with a result write-back edge cannot occur, because busy blocks it. If it is forced, the result write wins.
- MDU_out is read combinationally from the current HI/LO registers. A value written at edge E is visible from the cycle after E.

Optional Feature:
- Macro: MDU_DIVZERO_FAST_EN
- Defined: div/divu with B=0 at start does not enter RUN. busy stays 0, HI/LO unchanged, next op accepted in T+1.
- Undefined: divide-by-zero runs the full DIV_CYCLES with busy=1 and then leaves HI/LO unchanged.

Test Plan:
- Reset, then idle → busy=0, HI=0, LO=0, MDU_out=0.
- mult, A=0xFFFFFFFF, B=2, start in cycle 0:
  - busy=1 cycles 1..5.
  - Cycle 6: HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - multu with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- div, A=0xFFFFFFF9 (−7), B=2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- div, A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
- Preset HI=0x12345678 via mthi, then divu with B=0:
  - HI unchanged.
  - busy 10 cycles without MDU_DIVZERO_FAST_EN; busy never high with it.
- Req=1 with start (mult 3×4) → busy stays 0, LO unchanged.
- Reset asserted in cycle 3 of a div → busy=0, HI=LO=0 next cycle, no later write-back.
